// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - request/result bundle for the sequential binary-to-BCD converter
//
// Purpose: groups the operand/start request and the BCD result/status
//          signals of bin2bcd_seq so that the converter and its driver
//          share one port.
// Parameters:
//   BIN_W   width of the binary operand
//   DIGITS  number of packed BCD digits in the result
// Signals:
//   i_bin    binary operand, sampled when a start is accepted
//   i_start  conversion request (level)
//   o_bcd    packed BCD result, digit 0 in [3:0]
//   o_busy   high while the converter is shifting
//   o_done   one-cycle pulse, o_bcd/o_ovf valid
//   o_ovf    operand exceeded the displayable range
// Modports:
//   master  drives the request, observes the result (requester side)
//   slave   consumes the request, drives the result (converter side)

interface bin2bcd_seq_if #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
);
    logic [BIN_W-1:0]    i_bin;
    logic                i_start;
    logic [4*DIGITS-1:0] o_bcd;
    logic                o_busy;
    logic                o_done;
    logic                o_ovf;

    modport master (
        output i_bin,
        output i_start,
        input  o_bcd,
        input  o_busy,
        input  o_done,
        input  o_ovf
    );

    modport slave (
        input  i_bin,
        input  i_start,
        output o_bcd,
        output o_busy,
        output o_done,
        output o_ovf
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary-to-BCD converter
//
// Purpose: converts a BIN_W-bit binary value into DIGITS packed BCD digits,
//          one operand bit per clock, for the seven-segment scanner. The
//          result is held stable on o_bcd between conversions.
// Parameters:
//   BIN_W   width of the binary operand (default 27)
//   DIGITS  BCD digits kept (default 8, o_bcd is 4*DIGITS bits)
// Ports:
//   clk     system clock, everything on posedge
//   reset   synchronous, active-high; overrides everything incl. mid-conversion
//   bus     bin2bcd_seq_if.slave: i_bin, i_start in; o_bcd, o_busy, o_done, o_ovf out
// Build option:
//   BCD_SAT_EN  when defined, an operand above 10^DIGITS-1 saturates o_bcd to
//               all nines and raises o_ovf; otherwise o_bcd = i_bin mod 10^DIGITS
//               and o_ovf is constant 0.

module bin2bcd_seq #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic          clk,
    input  logic          reset,
    bin2bcd_seq_if.slave  bus
);
    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [BIN_W-1:0] bin_sr;
    logic [W-1:0]     work;
    logic [W-1:0]     work_next;
    logic [W-5:0]     adj_lo;
    logic [3:0]       top;
    logic [2:0]       top_lo;
    logic [W-1:0]     bcd_q;
    logic             done_q;

    // Add-3 on every digit below the top one.
    always_comb begin
        adj_lo = work[W-5:0];
        for (int d = 0; d < DIGITS - 1; d++) begin
            if (work[4*d +: 4] >= 4'd5) begin
                adj_lo[4*d +: 4] = work[4*d +: 4] + 4'd3;
            end
        end
    end

    // Only the low three bits of the adjusted top digit survive the shift;
    // its bit 3 is the carry worth 10^DIGITS and is dropped.
    assign top       = work[W-1 -: 4];
    assign top_lo    = (top >= 4'd5) ? top[2:0] + 3'd3 : top[2:0];
    assign work_next = {top_lo, adj_lo, bin_sr[BIN_W-1]};

`ifdef BCD_SAT_EN
    logic carry_flag;
    logic ovf_q;
    logic top_carry;

    // A valid top digit >= 5 becomes >= 8 after adjust, so it always carries out.
    assign top_carry = (top >= 4'd5);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            bin_sr <= '0;
            work   <= '0;
            bcd_q  <= '0;
            done_q <= 1'b0;
`ifdef BCD_SAT_EN
            carry_flag <= 1'b0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        bin_sr <= bus.i_bin;
                        work   <= '0;
                        cnt    <= '0;
`ifdef BCD_SAT_EN
                        carry_flag <= 1'b0;
`endif
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    work   <= work_next;
                    bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
                    cnt    <= cnt + 1'b1;
`ifdef BCD_SAT_EN
                    carry_flag <= carry_flag | top_carry;
`endif
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
`ifdef BCD_SAT_EN
                    bcd_q <= carry_flag ? {DIGITS{4'h9}} : work;
                    ovf_q <= carry_flag;
`else
                    bcd_q <= work;
`endif
                    // A start seen here chains straight into the next conversion.
                    if (bus.i_start) begin
                        bin_sr <= bus.i_bin;
                        work   <= '0;
                        cnt    <= '0;
`ifdef BCD_SAT_EN
                        carry_flag <= 1'b0;
`endif
                        state  <= SHIFT;
                    end else begin
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_bcd  = bcd_q;
    assign bus.o_busy = (state == SHIFT);
    assign bus.o_done = done_q;
`ifdef BCD_SAT_EN
    assign bus.o_ovf  = ovf_q;
`else
    assign bus.o_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq

module tb_bin2bcd_seq;
    logic clk;
    logic reset;
    int   checks;
    int   passes;

    bin2bcd_seq_if #(.BIN_W(27), .DIGITS(8)) bus ();

    bin2bcd_seq #(.BIN_W(27), .DIGITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts a conversion and waits (bounded) for o_done; performs no checks.
    task automatic run_conv(input logic [26:0] v, output int edges, output int busy_cyc,
                            output logic [31:0] bcd, output logic ovf);
        @(negedge clk);
        bus.i_bin   = v;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        busy_cyc = bus.o_busy ? 1 : 0;
        edges = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_busy) busy_cyc++;
            if (bus.o_done) begin
                edges = k;
                break;
            end
        end
        bcd = bus.o_bcd;
        ovf = bus.o_ovf;
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        bus.i_start = 1'b0;
        bus.i_bin   = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.o_bcd !== 32'h0) $display("FAIL reset_bcd got %h want 00000000", bus.o_bcd); else passes++;
        checks++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.o_busy); else passes++;
        checks++; if (bus.o_done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.o_done); else passes++;
        checks++; if (bus.o_ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus.o_ovf); else passes++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int edges, busy_cyc;
        logic [31:0] bcd;
        logic ovf;
        run_conv(27'd12345678, edges, busy_cyc, bcd, ovf);
        checks++; if (edges !== 28) $display("FAIL basic_latency got %0d want 28", edges); else passes++;
        checks++; if (busy_cyc !== 27) $display("FAIL basic_busy_cycles got %0d want 27", busy_cyc); else passes++;
        checks++; if (bcd !== 32'h12345678) $display("FAIL basic_bcd got %h want 12345678", bcd); else passes++;
        checks++; if (ovf !== 1'b0) $display("FAIL basic_ovf got %b want 0", ovf); else passes++;
        @(posedge clk);
        #1;
        checks++; if (bus.o_done !== 1'b0) $display("FAIL done_pulse_width got %b want 0", bus.o_done); else passes++;
        checks++; if (bus.o_bcd !== 32'h12345678) $display("FAIL bcd_hold got %h want 12345678", bus.o_bcd); else passes++;
    endtask

    task automatic test_boundaries;
        int edges, busy_cyc;
        logic [31:0] bcd;
        logic ovf;
        run_conv(27'd0, edges, busy_cyc, bcd, ovf);
        checks++; if (bcd !== 32'h00000000) $display("FAIL zero_bcd got %h want 00000000", bcd); else passes++;
        run_conv(27'd99999999, edges, busy_cyc, bcd, ovf);
        checks++; if (bcd !== 32'h99999999) $display("FAIL max_bcd got %h want 99999999", bcd); else passes++;
        checks++; if (ovf !== 1'b0) $display("FAIL max_ovf got %b want 0", ovf); else passes++;
        run_conv(27'd9, edges, busy_cyc, bcd, ovf);
        checks++; if (bcd !== 32'h00000009) $display("FAIL nine_bcd got %h want 00000009", bcd); else passes++;
        run_conv(27'd100000000, edges, busy_cyc, bcd, ovf);
`ifdef BCD_SAT_EN
        checks++; if (bcd !== 32'h99999999) $display("FAIL e8_bcd got %h want 99999999", bcd); else passes++;
        checks++; if (ovf !== 1'b1) $display("FAIL e8_ovf got %b want 1", ovf); else passes++;
`else
        checks++; if (bcd !== 32'h00000000) $display("FAIL e8_bcd got %h want 00000000", bcd); else passes++;
        checks++; if (ovf !== 1'b0) $display("FAIL e8_ovf got %b want 0", ovf); else passes++;
`endif
    endtask

    task automatic test_overflow;
        int edges, busy_cyc;
        logic [31:0] bcd;
        logic ovf;
        run_conv(27'd134217727, edges, busy_cyc, bcd, ovf);
        checks++; if (edges !== 28) $display("FAIL ovf_latency got %0d want 28", edges); else passes++;
`ifdef BCD_SAT_EN
        checks++; if (bcd !== 32'h99999999) $display("FAIL ovf_bcd got %h want 99999999", bcd); else passes++;
        checks++; if (ovf !== 1'b1) $display("FAIL ovf_flag got %b want 1", ovf); else passes++;
`else
        checks++; if (bcd !== 32'h34217727) $display("FAIL ovf_bcd got %h want 34217727", bcd); else passes++;
        checks++; if (ovf !== 1'b0) $display("FAIL ovf_flag got %b want 0", ovf); else passes++;
`endif
    endtask

    task automatic test_ignore_start;
        int edges;
        @(negedge clk);
        bus.i_bin   = 27'd5;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        edges = -1;
        for (int k = 1; k <= 60; k++) begin
            if (k == 10) begin
                bus.i_bin   = 27'd7;
                bus.i_start = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.i_start = 1'b0;
            if (bus.o_done) begin
                edges = k;
                break;
            end
        end
        checks++; if (edges !== 28) $display("FAIL ignore_latency got %0d want 28", edges); else passes++;
        checks++; if (bus.o_bcd !== 32'h00000005) $display("FAIL ignore_bcd got %h want 00000005", bus.o_bcd); else passes++;
    endtask

    task automatic test_back_to_back;
        int edges1, edges2;
        logic [31:0] bcd1;
        @(negedge clk);
        bus.i_bin   = 27'd12;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_bin = 27'd777;
        edges1 = -1;
        bcd1   = '0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_done) begin
                edges1 = k;
                bcd1   = bus.o_bcd;
                break;
            end
        end
        bus.i_start = 1'b0;
        edges2 = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_done) begin
                edges2 = k;
                break;
            end
        end
        checks++; if (edges1 !== 28) $display("FAIL b2b_first_latency got %0d want 28", edges1); else passes++;
        checks++; if (bcd1 !== 32'h00000012) $display("FAIL b2b_first_bcd got %h want 00000012", bcd1); else passes++;
        checks++; if (edges2 !== 28) $display("FAIL b2b_second_latency got %0d want 28", edges2); else passes++;
        checks++; if (bus.o_bcd !== 32'h00000777) $display("FAIL b2b_second_bcd got %h want 00000777", bus.o_bcd); else passes++;
    endtask

    task automatic test_reset_mid;
        int edges, busy_cyc, done_seen;
        logic [31:0] bcd;
        logic ovf;
        @(negedge clk);
        bus.i_bin   = 27'd999;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.o_busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", bus.o_busy); else passes++;
        checks++; if (bus.o_bcd !== 32'h0) $display("FAIL midrst_bcd got %h want 00000000", bus.o_bcd); else passes++;
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 35; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_done || bus.o_busy) done_seen++;
        end
        checks++; if (done_seen !== 0) $display("FAIL midrst_quiet got %0d active cycles want 0", done_seen); else passes++;
        run_conv(27'd42, edges, busy_cyc, bcd, ovf);
        checks++; if (bcd !== 32'h00000042) $display("FAIL after_rst_bcd got %h want 00000042", bcd); else passes++;
        checks++; if (edges !== 28) $display("FAIL after_rst_latency got %0d want 28", edges); else passes++;
    endtask

    initial begin
        checks      = 0;
        passes      = 0;
        reset       = 1'b1;
        bus.i_start = 1'b0;
        bus.i_bin   = '0;
        test_reset();
        test_basic();
        test_boundaries();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
